// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared widths and arithmetic helpers for the filter output stages
package filt_pkg;

  // Widest signed value the helpers handle; bitwidth+LOG2R+1 must not exceed it.
  localparam int MAX_W = 64;

  // Accumulator width: one extra bit per doubling of the block length.
  function automatic int acc_w(input int bw, input int log2r);
    return bw + log2r;
  endfunction

  // Occupancy counter width; it must be able to hold the value depth itself.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic signed [MAX_W-1:0] t;
    t = $signed(v << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

  // Divide by 2^sh, rounding half up; sh=0 returns v unchanged.
  function automatic logic signed [MAX_W-1:0] round_shift(input logic signed [MAX_W-1:0] v,
                                                           input int sh);
    logic signed [MAX_W-1:0] t;
    t = v;
    if (sh > 0) t = t + (MAX_W'(1) << (sh - 1));
    return t >>> sh;
  endfunction

endpackage

// File: rtl/iir_decim_if.sv
// rtl/iir_decim_if.sv - sample input and decimated output bundle of iir_decim
interface iir_decim_if #(
  parameter int bitwidth   = 32,
  parameter int FIFO_DEPTH = 4
) ();
  logic                                       x_valid;
  logic [bitwidth-1:0]                        x;
  logic                                       sync;
  logic                                       y_valid;
  logic                                       y_ready;
  logic [bitwidth-1:0]                        y;
  logic [filt_pkg::level_w(FIFO_DEPTH)-1:0]   level;
  logic                                       overflow;

  // Upstream filter and downstream consumer side.
  modport master (
    output x_valid, x, sync, y_ready,
    input  y_valid, y, level, overflow
  );

  // Decimator side.
  modport slave (
    input  x_valid, x, sync, y_ready,
    output y_valid, y, level, overflow
  );
endinterface

// File: rtl/filt_sync_fifo.sv
// rtl/filt_sync_fifo.sv - first-word fall-through synchronous FIFO, push allowed while full if popping
module filt_sync_fifo
  import filt_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 4,
  localparam int LW    = level_w(depth),
  localparam int PTR_W = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(depth));
  assign level = count_q;
  // Head entry is visible as soon as it is stored; zero keeps the bus quiet when empty.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state: pointer advance, storage write and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    // When full, the slot being written is the one the pop frees this edge.
    do_push  = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage needs no reset since dout is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/iir_decim.sv
// rtl/iir_decim.sv - block-average decimator with rounding and buffered valid/ready output
module iir_decim
  import filt_pkg::*;
#(
  parameter int bitwidth   = 32,
  parameter int LOG2R      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  iir_decim_if.slave bus
);

  localparam int R     = 1 << LOG2R;
  localparam int ACC_W = acc_w(bitwidth, LOG2R);
  localparam int LW    = level_w(FIFO_DEPTH);
  localparam int PH_W  = (LOG2R > 0) ? LOG2R : 1;

  logic [PH_W-1:0]     phase_q, phase_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                overflow_q, overflow_d;

  logic signed [MAX_W-1:0] x_ext, acc_ext, sum;
  logic                phase_first, phase_last;
  logic                dump;
  logic [bitwidth-1:0] r;

  logic                fifo_empty, fifo_full, fifo_pop;
  logic [bitwidth-1:0] fifo_dout;
  logic [LW-1:0]       fifo_level;

  assign fifo_pop     = bus.y_ready & ~fifo_empty;
  assign bus.y_valid  = ~fifo_empty;
  assign bus.y        = fifo_dout;
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_q;

  // Block accumulation, dump decision and sticky overflow tracking.
  always_comb begin
    phase_d     = phase_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    dump        = 1'b0;
    phase_first = (phase_q == '0);
    phase_last  = (phase_q == PH_W'(R - 1));
    x_ext       = sext(MAX_W'(bus.x), bitwidth);
    acc_ext     = sext(MAX_W'(acc_q), ACC_W);
    // The first sample of a block replaces whatever the accumulator held.
    sum         = (phase_first ? '0 : acc_ext) + x_ext;
    r           = bitwidth'(round_shift(sum, LOG2R));
    if (bus.sync) begin
      // Realign: a concurrent sample opens the new block and never dumps.
      phase_d    = '0;
      acc_d      = '0;
      overflow_d = 1'b0;
      if (bus.x_valid) begin
        phase_d = (R == 1) ? '0 : PH_W'(1);
        acc_d   = ACC_W'(x_ext);
      end
    end else if (bus.x_valid) begin
      acc_d   = ACC_W'(sum);
      phase_d = phase_last ? '0 : phase_q + PH_W'(1);
      dump    = phase_last;
      if (phase_last && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end
  end

  // Accumulator, phase and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  filt_sync_fifo #(
    .width (bitwidth),
    .depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .din   (r),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

endmodule

// File: doc/iir_decim.md
Name: iir_decim

Overview:
Decimating output stage placed directly downstream of the iir_N cascade. It averages each block of R = 2^LOG2R consecutive filtered samples into one output sample, with round-half-up. Results are buffered in a small FIFO and presented on a valid/ready interface to the consumer (DAC framer / bus writer). Data is the same two's-complement encoded sequence the filter cascade produces.

Parameters:
bitwidth, 32, width of encoded sample (two's complement)
LOG2R, 2, log2 of decimation ratio R (0 = pass-through, R=1)
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
x_valid  input  1  x carries a sample this cycle (tie 1 for a free-running iir_N)
x  input  bitwidth  filtered sample from iir_N output y
sync  input  1  restart block alignment; clears overflow
y_valid  output  1  FIFO non-empty; y holds head entry
y_ready  input  1  consumer accepts head when y_valid & y_ready
y  output  bitwidth  decimated sample (head of FIFO); 0 when y_valid=0
level  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
overflow  output  1  sticky: a decimated result was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at an edge): phase=0, acc=0, FIFO empty, y_valid=0, y=0, level=0, overflow=0. Reset takes priority over every other input. Mid-block reset discards the partial sum and all FIFO contents.
- acc is signed, bitwidth+LOG2R bits wide; x is sign-extended. phase counter runs 0..R-1.
- Accepted sample (x_valid=1): if phase==0, acc<=sext(x); else acc<=acc+sext(x). phase<=phase+1, wrapping R-1 -> 0.
- Dump: an accepted sample with phase==R-1 yields r = (acc + sext(x) + 2^(LOG2R-1)) >>> LOG2R, truncated to bitwidth (the result always fits). r is pushed into the FIFO at that same edge.
- For LOG2R=0, r = x. No rounding term is applied.
- Latency: y_valid rises in the cycle after the edge that accepts the R-th sample, provided the FIFO was empty.
- sync=1: phase<=0 and acc is cleared, overflow<=0; FIFO contents are kept.
- sync with x_valid in the same cycle: the sample becomes the first of the new block (phase<=1, acc<=sext(x)). No dump occurs in that cycle, even if the old phase was R-1.
- FIFO pop happens at an edge with y_valid & y_ready. The next entry, or 0 when the FIFO becomes empty, appears in the following cycle.
- Push with FIFO full and no pop: r is dropped, FIFO unchanged, overflow<=1.
- Push with FIFO full and a pop in the same cycle: both happen, level stays FIFO_DEPTH, no overflow.
- Push and pop on an empty FIFO in the same cycle: a pop cannot occur because y_valid=0, so only the push happens.
- Order: output order equals dump order; pointers wrap modulo FIFO_DEPTH.
- y_ready=1 with y_valid=0: ignored.
- overflow is cleared only by rst or sync. If sync and a dropping push occur in the same cycle, sync has priority: overflow=0 and no dump occurs.

Decomposition:
- Shared package filt_pkg holds:
  - sign-extension helper.
  - round-and-arithmetic-shift helper: (value, shift) -> rounded, shifted result.
  - ACC_W = bitwidth+LOG2R derivation.
  - clog2-based LEVEL_W constant.
- One sub-module, filt_sync_fifo: parameters width and depth; ports clk, rst, push, din, pop, dout, empty, full, level; same-cycle push/pop when full allowed; first-word fall-through.
- The accumulator, phase counter and overflow logic live in iir_decim.

Test Plan:
- LOG2R=2: after rst, x=1,2,3,4 on 4 consecutive cycles, y_ready=1 -> single y=3 with y_valid one cycle after the 4th sample; y_valid drops the next cycle.
- x=-1,-2,-3,-4 -> y=-2 (0xFFFFFFFE), since -2.5 rounds half up. x=0x7FFFFFFF ×4 -> y=0x7FFFFFFF.
- x_valid toggling 1,0,1,0… with x=5 on the valid cycles -> y=5 after exactly 4 accepted samples; invalid-cycle x values are ignored.
- y_ready=0, 5 full blocks of x=block index (1,2,3,4,5) -> level=4, overflow=1, then y_ready=1 -> drains 1,2,3,4 in order and level returns to 0.
- Full FIFO, y_ready=1 in the cycle a 5th block dumps -> level stays 4, overflow=0, and the new entry appears after the 3 older ones.
- After 2 samples of 9, sync=1 with x_valid=1, x=4, then x=4 ×3 -> one output y=4 with overflow=0. Separately, rst asserted after 3 samples -> no output; the next 4 samples start a fresh block.
